// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the instruction prefetch stage.
// Used by prefetch_fifo and prefetch_buffer.
package prefetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // What happens to a memory response in the current cycle
    typedef enum logic [1:0] {
        RSP_NONE   = 2'd0,
        RSP_DROP   = 2'd1,
        RSP_PUSH   = 2'd2,
        RSP_BYPASS = 2'd3
    } rsp_action_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + XLEN'(4);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch entries; flush outranks push and pop.
// Push while full is accepted only together with a pop.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    output fetch_entry_t o_head,
    output logic         o_empty,
    output logic [CW-1:0] o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_count   = r_count;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch stage: owns the fetch PC, queues returned words, handles redirects.
// Optional same-cycle bypass of an empty queue when PREFETCH_BYPASS_EN is defined.
module prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCTarget_E,
    input  logic            PCSrc_E,
    input  logic            Stall_F,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] PC_F,
    output logic [ILEN-1:0] Instr_F,
    output logic            Valid_F
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int OCCW = CW + 1;

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic [OCCW-1:0] w_occupancy;
    logic            w_room;
    logic            w_req_fire;
    logic            w_fifo_pop;
    logic [CW-1:0]   w_inflight_next;
    logic [XLEN-1:0] w_target;
    rsp_action_e     w_action;

    // Queued plus outstanding words never exceed DEPTH, so a push always fits
    assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign w_room      = (w_occupancy < OCCW'(DEPTH));

    assign imem_req_valid = !rst && !PCSrc_E && w_room;
    assign imem_req_addr  = r_fpc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_target        = align_word(PCTarget_E);
    assign w_inflight_next = r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
    assign w_fifo_pop      = !w_fifo_empty && !Stall_F;
    assign w_push_data     = '{pc: r_rsp_pc, instr: imem_rsp_data};

    always_comb begin
        w_action = RSP_NONE;
        if (imem_rsp_valid) begin
            if (PCSrc_E || (r_drop != '0)) begin
                w_action = RSP_DROP;
`ifdef PREFETCH_BYPASS_EN
            end else if (w_fifo_empty && !Stall_F && !rst) begin
                w_action = RSP_BYPASS;
`endif
            end else begin
                w_action = RSP_PUSH;
            end
        end
    end

    // A redirect re-targets both PCs and kills everything still outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fpc      <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (PCSrc_E) begin
                r_fpc    <= w_target;
                r_rsp_pc <= w_target;
                r_drop   <= w_inflight_next;
            end else begin
                if (w_req_fire) begin
                    r_fpc <= next_word(r_fpc);
                end
                if (w_action == RSP_DROP) begin
                    r_drop <= r_drop - CW'(1);
                end
                if ((w_action == RSP_PUSH) || (w_action == RSP_BYPASS)) begin
                    r_rsp_pc <= next_word(r_rsp_pc);
                end
            end
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (PCSrc_E),
        .i_push  (w_action == RSP_PUSH),
        .i_data  (w_push_data),
        .i_pop   (w_fifo_pop),
        .o_head  (w_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        Valid_F = !w_fifo_empty;
        PC_F    = w_head.pc;
        Instr_F = w_head.instr;
        if (w_action == RSP_BYPASS) begin
            Valid_F = 1'b1;
            PC_F    = r_rsp_pc;
            Instr_F = imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Directed bench for prefetch_buffer with an in-order fixed-latency memory model.
// Expected Valid_F latency follows PREFETCH_BYPASS_EN when it is defined.
module tb_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h1000;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] PCTarget_E;
    logic        PCSrc_E;
    logic        Stall_F;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [63:0] PC_F;
    logic [31:0] Instr_F;
    logic        Valid_F;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [63:0] expPc;
    logic [63:0] expReq;
    int          accepted;
    int          popped;

    logic        memVld  [8];
    logic [63:0] memAddr [8];
    logic [2:0]  memLatM1;

    prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCTarget_E     (PCTarget_E),
        .PCSrc_E        (PCSrc_E),
        .Stall_F        (Stall_F),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PC_F           (PC_F),
        .Instr_F        (Instr_F),
        .Valid_F        (Valid_F)
    );

    always #5 clk = ~clk;

    // Memory returns each accepted word exactly memLatM1+1 cycles later, data = addr>>2
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) memVld[i] <= 1'b0;
        end else begin
            memVld[0]  <= imem_req_valid && imem_req_ready;
            memAddr[0] <= imem_req_addr;
            for (int i = 1; i < 8; i++) begin
                memVld[i]  <= memVld[i-1];
                memAddr[i] <= memAddr[i-1];
            end
        end
    end

    always_comb begin
        imem_rsp_valid = memVld[memLatM1];
        imem_rsp_data  = memAddr[memLatM1][33:2];
    end

    task automatic test_reset();
        rst = 1'b1; PCSrc_E = 1'b0; Stall_F = 1'b0; PCTarget_E = '0;
        imem_req_ready = 1'b1; memLatM1 = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        nCompared++;
        if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        nCompared++;
        if (imem_req_addr !== RESET_PC) begin nMismatched++; $display("[TB] FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC); end
        nCompared++;
        if (Valid_F !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", Valid_F); end
        nCompared++;
        if (PC_F !== 64'h0) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h expected 0", PC_F); end
        nCompared++;
        if (Instr_F !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_instr: got %h expected 0", Instr_F); end
        expPc = RESET_PC; expReq = RESET_PC; accepted = 0; popped = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            if (k == 1) begin
                nCompared++;
                if (imem_req_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL first_req_valid: got %b expected 1", imem_req_valid); end
            end
            if (k == 2) begin
                nCompared++;
                if (Valid_F !== BYPASS) begin nMismatched++; $display("[TB] FAIL rsp_cycle_valid: got %b expected %b", Valid_F, BYPASS); end
            end
            if (k == 3) begin
                nCompared++;
                if (Valid_F !== 1'b1) begin nMismatched++; $display("[TB] FAIL rsp_next_valid: got %b expected 1", Valid_F); end
            end
            if (imem_req_valid && imem_req_ready) begin
                nCompared++;
                if (imem_req_addr !== expReq) begin nMismatched++; $display("[TB] FAIL reset_req_seq: got %h expected %h", imem_req_addr, expReq); end
                expReq = expReq + 64'd4; accepted++;
            end
            if (Valid_F === 1'b1 && !Stall_F && !PCSrc_E) begin
                nCompared++;
                if (PC_F !== expPc || Instr_F !== expPc[33:2]) begin nMismatched++; $display("[TB] FAIL reset_stream: got %h/%h expected %h/%h", PC_F, Instr_F, expPc, expPc[33:2]); end
                expPc = expPc + 64'd4; popped++;
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] heldPc;
        heldPc = '0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            Stall_F = (k >= 4 && k < 10);
            #1;
            if (k == 5) heldPc = PC_F;
            if (k >= 6 && k < 10) begin
                nCompared++;
                if (Valid_F !== 1'b1 || PC_F !== heldPc) begin nMismatched++; $display("[TB] FAIL stall_head: got %b/%h expected 1/%h", Valid_F, PC_F, heldPc); end
            end
            if (k == 9) begin
                nCompared++;
                if ((accepted - popped) != DEPTH || imem_req_valid !== 1'b0) begin
                    nMismatched++; $display("[TB] FAIL stall_capacity: got occ %0d req %b expected occ %0d req 0", accepted - popped, imem_req_valid, DEPTH);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                nCompared++;
                if (imem_req_addr !== expReq) begin nMismatched++; $display("[TB] FAIL stall_req_seq: got %h expected %h", imem_req_addr, expReq); end
                expReq = expReq + 64'd4; accepted++;
            end
            if (Valid_F === 1'b1 && !Stall_F && !PCSrc_E) begin
                nCompared++;
                if (PC_F !== expPc || Instr_F !== expPc[33:2]) begin nMismatched++; $display("[TB] FAIL stall_stream: got %h/%h expected %h/%h", PC_F, Instr_F, expPc, expPc[33:2]); end
                expPc = expPc + 64'd4; popped++;
            end
        end
    endtask

    task automatic test_redirect();
        int p0;
        p0 = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k == 8) memLatM1 = 3'd2;
            imem_req_ready = !(k < 8);
            PCSrc_E = (k == 11);
            PCTarget_E = 64'h2002;
            if (k == 11) begin expPc = 64'h2000; expReq = 64'h2000; p0 = popped; end
            #1;
            if (k == 11) begin
                nCompared++;
                if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL redirect_no_req: got %b expected 0", imem_req_valid); end
            end
            if (k == 12) begin
                nCompared++;
                if (Valid_F !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000) begin
                    nMismatched++; $display("[TB] FAIL redirect_next: got valid %b req %b addr %h expected 0 1 2000", Valid_F, imem_req_valid, imem_req_addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                nCompared++;
                if (imem_req_addr !== expReq) begin nMismatched++; $display("[TB] FAIL redirect_req_seq: got %h expected %h", imem_req_addr, expReq); end
                expReq = expReq + 64'd4; accepted++;
            end
            if (Valid_F === 1'b1 && !Stall_F && !PCSrc_E) begin
                nCompared++;
                if (PC_F !== expPc || Instr_F !== expPc[33:2]) begin nMismatched++; $display("[TB] FAIL redirect_stream: got %h/%h expected %h/%h", PC_F, Instr_F, expPc, expPc[33:2]); end
                expPc = expPc + 64'd4; popped++;
            end
        end
        nCompared++;
        if (popped - p0 < 3) begin nMismatched++; $display("[TB] FAIL redirect_progress: got %0d expected at least 3", popped - p0); end
    endtask

    task automatic test_random_ready();
        bit done;
        int p0;
        done = 1'b0; p0 = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            PCSrc_E = 1'b0;
            if (k < 8) begin
                imem_req_ready = 1'b0; Stall_F = 1'b0;
            end else if (k < 70) begin
                if (k == 8) memLatM1 = 3'd1;
                imem_req_ready = 1'($urandom_range(0, 1));
                Stall_F = ($urandom_range(0, 3) == 0);
                if (!done && k >= 20 && (imem_rsp_valid || k == 50)) begin
                    PCSrc_E = 1'b1; PCTarget_E = 64'h3000; done = 1'b1;
                    expPc = 64'h3000; expReq = 64'h3000; p0 = popped;
                end
            end else begin
                imem_req_ready = 1'b1; Stall_F = 1'b0;
            end
            #1;
            if (PCSrc_E) begin
                nCompared++;
                if (imem_req_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL random_redirect_no_req: got %b expected 0", imem_req_valid); end
            end
            if (imem_req_valid && imem_req_ready) begin
                nCompared++;
                if (imem_req_addr !== expReq) begin nMismatched++; $display("[TB] FAIL random_req_seq: got %h expected %h", imem_req_addr, expReq); end
                expReq = expReq + 64'd4; accepted++;
            end
            if (Valid_F === 1'b1 && !Stall_F && !PCSrc_E) begin
                nCompared++;
                if (PC_F !== expPc || Instr_F !== expPc[33:2]) begin nMismatched++; $display("[TB] FAIL random_stream: got %h/%h expected %h/%h", PC_F, Instr_F, expPc, expPc[33:2]); end
                expPc = expPc + 64'd4; popped++;
            end
        end
        nCompared++;
        if (popped - p0 < 4) begin nMismatched++; $display("[TB] FAIL random_progress: got %0d expected at least 4", popped - p0); end
    endtask

    task automatic test_wrap();
        int p0;
        p0 = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            imem_req_ready = 1'b1; Stall_F = 1'b0;
            PCSrc_E = (k == 0);
            PCTarget_E = 64'hFFFF_FFFF_FFFF_FFF8;
            if (k == 0) begin expPc = 64'hFFFF_FFFF_FFFF_FFF8; expReq = 64'hFFFF_FFFF_FFFF_FFF8; p0 = popped; end
            #1;
            if (imem_req_valid && imem_req_ready) begin
                nCompared++;
                if (imem_req_addr !== expReq) begin nMismatched++; $display("[TB] FAIL wrap_req_seq: got %h expected %h", imem_req_addr, expReq); end
                expReq = expReq + 64'd4; accepted++;
            end
            if (Valid_F === 1'b1 && !Stall_F && !PCSrc_E) begin
                nCompared++;
                if (PC_F !== expPc || Instr_F !== expPc[33:2]) begin nMismatched++; $display("[TB] FAIL wrap_stream: got %h/%h expected %h/%h", PC_F, Instr_F, expPc, expPc[33:2]); end
                expPc = expPc + 64'd4; popped++;
            end
        end
        nCompared++;
        if (popped - p0 < 4) begin nMismatched++; $display("[TB] FAIL wrap_progress: got %0d expected at least 4", popped - p0); end
    endtask

    initial begin
        $display("[TB] prefetch_buffer bench start (bypass=%0b)", BYPASS);
        test_reset();
        test_stall();
        test_redirect();
        test_random_ready();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
